// File: rtl/timer_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package timer_pkg;

  localparam int unsigned TIMER_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake, run controls and status of the countdown timer.
interface countdown_timer_if
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH_DEFAULT
);

  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             enable;
  logic             reload_en;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_value, enable, reload_en, abort,
    input  load_ready, count, busy, done
  );

  modport slave (
    input  load_valid, load_value, enable, reload_en, abort,
    output load_ready, count, busy, done
  );

endinterface

// File: rtl/count_down_core.sv
// WIDTH-bit down-count register with clear, load and decrement, plus a count==1 flag.
module count_down_core
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  // Clear wins over load, load over decrement; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with done pulse, abort and optional auto-reload.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  bus
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] reload_q;
  logic             reload_capture;
  logic             core_clear;
  logic             core_load;
  logic             core_dec;
  logic [WIDTH-1:0] core_value;
  logic             is_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '0;
    end else if (reload_capture) begin
      reload_q <= bus.load_value;
    end
  end

  always_comb begin
    state_next     = state;
    reload_capture = 1'b0;
    core_clear     = 1'b0;
    core_load      = 1'b0;
    core_dec       = 1'b0;
    core_value     = bus.load_value;
    case (state)
      IDLE: begin
        if (bus.load_valid) begin
          reload_capture = 1'b1;
          core_load      = 1'b1;
          state_next     = (bus.load_value == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          core_clear = 1'b1;
          state_next = IDLE;
        end else if (bus.enable) begin
          core_dec = 1'b1;
          if (is_one) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        // Count is already zero here; a reload restarts from the last accepted value.
        if (bus.reload_en && (reload_q != '0)) begin
          core_load  = 1'b1;
          core_value = reload_q;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        core_clear = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  count_down_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .clear  (core_clear),
    .load   (core_load),
    .dec    (core_dec),
    .value  (core_value),
    .count  (bus.count),
    .is_one (is_one)
  );

  // Status is a pure decode of the state register, so async reset reaches it at once.
  assign bus.load_ready = (state == IDLE);
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed table-driven bench for countdown_timer plus async-reset and max-load sequences.
module tb_countdown_timer;

  localparam int unsigned W = 4;

  typedef struct {
    logic         lv;
    logic [W-1:0] val;
    logic         en;
    logic         rl;
    logic         ab;
    logic [W-1:0] e_count;
    logic         e_busy;
    logic         e_done;
    logic         e_ready;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic drive(input logic lv, input logic [W-1:0] val, input logic en,
                       input logic rl, input logic ab);
    bus.load_valid = lv;
    bus.load_value = val;
    bus.enable     = en;
    bus.reload_en  = rl;
    bus.abort      = ab;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [W-1:0] c, input logic b,
                          input logic d, input logic r);
    chk({tag, ".count"}, int'(bus.count), int'(c));
    chk({tag, ".busy"}, int'(bus.busy), int'(b));
    chk({tag, ".done"}, int'(bus.done), int'(d));
    chk({tag, ".ready"}, int'(bus.load_ready), int'(r));
  endtask

  vec_t vecs[$];

  function automatic vec_t v(logic lv, logic [W-1:0] val, logic en, logic rl, logic ab,
                             logic [W-1:0] c, logic b, logic d, logic r);
    vec_t t;
    t.lv = lv; t.val = val; t.en = en; t.rl = rl; t.ab = ab;
    t.e_count = c; t.e_busy = b; t.e_done = d; t.e_ready = r;
    return t;
  endfunction

  initial begin
    int cyc;
    int done_cyc;
    n_checks = 0;
    n_pass   = 0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // load 5, enable high: 5,4,3,2,1,0(done),idle
    vecs.push_back(v(1, 5, 1, 0, 0, 5, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 4, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 3, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1));
    // load 3, enable 1,0,1,0,1: 3,2,2,1,1,0
    vecs.push_back(v(1, 3, 0, 0, 0, 3, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1));
    // load 0: immediate done, never busy
    vecs.push_back(v(1, 0, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 1));
    // load 2 with auto-reload, then drop reload_en
    vecs.push_back(v(1, 2, 1, 1, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 2, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1));
    // load 9, load_valid during RUN ignored, abort at 6 beats enable
    vecs.push_back(v(1, 9, 1, 0, 0, 9, 1, 0, 0));
    vecs.push_back(v(1, 3, 1, 0, 0, 8, 1, 0, 0));
    vecs.push_back(v(1, 3, 1, 0, 0, 7, 1, 0, 0));
    vecs.push_back(v(1, 3, 1, 0, 0, 6, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1));
    // abort ignored in IDLE; abort on first RUN cycle
    vecs.push_back(v(1, 4, 1, 0, 1, 4, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 1));

    #12;
    chk_outs("reset", 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_outs("idle_after_reset", 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].lv, vecs[i].val, vecs[i].en, vecs[i].rl, vecs[i].ab);
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy,
               vecs[i].e_done, vecs[i].e_ready);
    end

    // Async reset mid-count at 7 after loading 15
    drive(1'b1, 15, 1'b1, 1'b0, 1'b0);
    step();
    chk("load15.count", int'(bus.count), 15);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step();
    chk("pre_rst.count", int'(bus.count), 7);
    #2 rst = 1'b1;
    #1;
    chk_outs("async_rst", 0, 0, 0, 1);
    @(posedge clk);
    #1;
    chk_outs("rst_held", 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;

    // Reload 15 and count enabled cycles to done
    drive(1'b1, 15, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc      = 0;
    done_cyc = -1;
    while (cyc < 40 && done_cyc < 0) begin
      step();
      cyc++;
      if (bus.done) done_cyc = cyc;
    end
    chk("max_load.done_cycle", done_cyc, 15);
    chk("max_load.count_at_done", int'(bus.count), 0);
    step();
    chk_outs("max_load.after", 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
